// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial unsigned a-b with start/busy/done handshake
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sa, sb, res, res_n;
  logic [CW-1:0] cnt;
  logic br, br_n, last;
  always_comb begin
    br_n = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    res_n = {sa[0] ^ sb[0] ^ br, res[WIDTH-1:1]};
    last = cnt == CW'(WIDTH - 1);
    state_n = state == IDLE ? (start ? SHIFT : IDLE) :
              state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sa <= '0;
      sb <= '0;
      res <= '0;
      cnt <= '0;
      br <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      diff <= '0;
      borrow <= 1'b0;
    end else begin
      state <= state_n;
      busy <= state_n == SHIFT;
      done <= state_n == DONE;
      if (state == IDLE && start) begin
        sa <= a;
        sb <= b;
        br <= 1'b0;
        cnt <= '0;
      end
      if (state == SHIFT) begin
        sa <= sa >> 1;
        sb <= sb >> 1;
        br <= br_n;
        res <= res_n;
        cnt <= cnt + 1'b1;
      end
      if (state == SHIFT && last) begin
        diff <= res_n;
        borrow <= br_n;
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor against an arithmetic model
module tb_serial_subtractor;
  logic clk, reset, start, busy, done, borrow;
  logic [7:0] a, b, diff;
  int n_vec, n_err;
  logic [7:0] last_diff;
  logic last_borrow;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input bit scramble, input string tag);
    int k, nb;
    bit held;
    logic [7:0] ed;
    ed = 8'((32'(x) + 256 - 32'(y)) % 256);
    @(negedge clk);
    start = 1'b1;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    if (scramble) begin
      a = 8'h00;
      b = 8'hFF;
    end
    k = 0;
    nb = 0;
    held = 1'b1;
    while (!done && k < 20) begin
      if (busy) nb++;
      if (diff !== last_diff || borrow !== last_borrow) held = 1'b0;
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, 32'(k), 32'd8);
    chk({tag, "_busy_cycles"}, 32'(nb), 32'd8);
    chk({tag, "_held"}, 32'(held), 32'd1);
    chk({tag, "_diff"}, 32'(diff), 32'(ed));
    chk({tag, "_borrow"}, 32'(borrow), 32'(x < y));
    last_diff = ed;
    last_borrow = x < y;
    @(negedge clk);
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int k, nd, last_i, idle_bad;
    logic [15:0] q[$];
    logic [15:0] p;
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #2 reset = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    last_diff = 8'h00;
    last_borrow = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    do_op(8'h35, 8'h12, 1'b0, "basic");
    do_op(8'h00, 8'h01, 1'b0, "wrap0m1");
    do_op(8'hFF, 8'hFF, 1'b0, "equal");
    do_op(8'h80, 8'h81, 1'b0, "wrap80");
    @(negedge clk);
    start = 1'b1;
    a = 8'h10;
    b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    @(negedge clk);
    start = 1'b0;
    k = 2;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ign_latency", 32'(k), 32'd8);
    chk("ign_diff", 32'(diff), 32'h0F);
    chk("ign_borrow", 32'(borrow), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle_bad = 0;
    repeat (12) begin
      if (busy || done) idle_bad++;
      @(negedge clk);
    end
    chk("ign_no_second_op", 32'(idle_bad), 32'd0);
    last_diff = 8'h0F;
    last_borrow = 1'b0;
    do_op(8'h64, 8'h14, 1'b1, "scramble");
    @(negedge clk);
    start = 1'b1;
    a = 8'h55;
    b = 8'h22;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_borrow", 32'(borrow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle_bad = 0;
    repeat (12) begin
      if (busy || done) idle_bad++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(idle_bad), 32'd0);
    last_diff = 8'h00;
    last_borrow = 1'b0;
    do_op(8'h09, 8'h03, 1'b0, "after_abort");
    repeat (4) do_op(8'($urandom), 8'($urandom), 1'b0, "rand");
    nd = 0;
    last_i = -1;
    for (int i = 0; i <= 80; i++) begin
      @(negedge clk);
      if (done) begin
        if (q.size() > 0) begin
          p = q.pop_front();
          chk("b2b_diff", 32'(diff), 32'(8'((32'(p[15:8]) + 256 - 32'(p[7:0])) % 256)));
          chk("b2b_borrow", 32'(borrow), 32'(p[15:8] < p[7:0]));
        end
        if (last_i >= 0) chk("b2b_gap", 32'(i - last_i), 32'd10);
        last_i = i;
        nd++;
      end
      a = 8'($urandom);
      b = 8'($urandom);
      start = 1'b1;
      if (i % 10 == 0) q.push_back({a, b});
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("b2b_count", 32'(nd), 32'd8);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
